// File: rtl/beta_fetch_pc.sv
// beta_fetch_pc: PC generation and instruction fetch stage.
// Issues in-order word fetches, tags each with its PC and buffers the
// returned instructions for decode. Redirects from execute flush the
// buffer and drop responses still in flight from the old path.
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   imem_req_o/addr_o       fetch request and word address
//   imem_gnt_i              request accepted this cycle
//   imem_rvalid_i/rdata_i   in-order response
//   redirect_i/pc_i         PC change from branch/jump unit
//   redirect_misalig_i      target misaligned, redirect rejected
//   if_valid_o/instr_o/pc_o instruction to decode
//   if_ready_i              decode pops when valid & ready
//   if_misalig_exc_o        one-cycle pulse on rejected redirect

module beta_fetch_pc #(
    parameter int                   DATAWIDTH  = 32,
    parameter logic [DATAWIDTH-1:0] BOOT_ADDR  = 32'h0000_0000,
    parameter int                   FIFO_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 imem_req_o,
    output logic [DATAWIDTH-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DATAWIDTH-1:0] imem_rdata_i,
    input  logic                 redirect_i,
    input  logic [DATAWIDTH-1:0] redirect_pc_i,
    input  logic                 redirect_misalig_i,
    output logic                 if_valid_o,
    output logic [DATAWIDTH-1:0] if_instr_o,
    output logic [DATAWIDTH-1:0] if_pc_o,
    input  logic                 if_ready_i,
    output logic                 if_misalig_exc_o
);

    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNTW:0] DEPTH_W = (CNTW + 1)'(FIFO_DEPTH);
    localparam logic [DATAWIDTH-1:0] PC_STEP = DATAWIDTH'(4);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_FLUSH
    } state_t;

    state_t               r_state;
    logic [DATAWIDTH-1:0] r_pc;
    logic [CNTW-1:0]      r_outstanding;
    logic [CNTW-1:0]      r_discard;
    logic [CNTW-1:0]      r_count;
    logic [PTRW-1:0]      r_rd_ptr;
    logic [PTRW-1:0]      r_wr_ptr;
    logic [PTRW-1:0]      r_tag_rd;
    logic [PTRW-1:0]      r_tag_wr;
    logic                 r_exc;

    logic [DATAWIDTH-1:0] r_buf_pc    [FIFO_DEPTH];
    logic [DATAWIDTH-1:0] r_buf_instr [FIFO_DEPTH];
    logic [DATAWIDTH-1:0] r_tag       [FIFO_DEPTH];

    logic                 w_redir;
    logic                 w_req;
    logic                 w_issue;
    logic                 w_resp;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_valid;
    logic [CNTW:0]        w_inflight;
    logic [CNTW-1:0]      w_out_next;

    assign w_redir    = redirect_i & ~redirect_misalig_i;
    assign w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
    // Outstanding fetches plus buffered entries never exceed the buffer
    // size, so every response is guaranteed a slot.
    assign w_req      = (r_state == S_FETCH) && (w_inflight < DEPTH_W);
    assign w_issue    = w_req & imem_gnt_i;
    // A response with nothing outstanding is a protocol error; dropped.
    assign w_resp     = imem_rvalid_i & (r_outstanding != '0);
    assign w_drop     = w_resp & (r_discard != '0);
    assign w_push     = w_resp & ~w_drop & ~w_redir;
    assign w_valid    = (r_count != '0);
    assign w_pop      = if_ready_i & w_valid & ~w_redir;
    assign w_out_next = r_outstanding + CNTW'(w_issue) - CNTW'(w_resp);

    assign imem_req_o       = w_req;
    assign imem_addr_o      = r_pc;
    assign if_valid_o       = w_valid;
    assign if_instr_o       = w_valid ? r_buf_instr[r_rd_ptr] : '0;
    assign if_pc_o          = w_valid ? r_buf_pc[r_rd_ptr] : '0;
    assign if_misalig_exc_o = r_exc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_BOOT;
            r_pc          <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
            r_exc         <= 1'b0;
        end else begin
            r_exc         <= redirect_i & redirect_misalig_i;
            r_outstanding <= w_out_next;

            // Tag queue tracks every issued fetch, old path or not,
            // so it stays aligned with the response stream.
            if (w_issue) begin
                r_tag_wr <= r_tag_wr + PTRW'(1);
            end
            if (w_resp) begin
                r_tag_rd <= r_tag_rd + PTRW'(1);
            end

            if (w_redir) begin
                r_pc <= redirect_pc_i;
            end else if (w_issue) begin
                r_pc <= r_pc + PC_STEP;
            end

            if (w_redir) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTRW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTRW'(1);
                end
                r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
            end

            // Everything still in flight after this edge is old path.
            if (w_redir) begin
                r_discard <= w_out_next;
            end else if (w_drop) begin
                r_discard <= r_discard - CNTW'(1);
            end

            unique case (r_state)
                S_BOOT: begin
                    r_state <= S_FETCH;
                end
                S_FETCH, S_FLUSH: begin
                    if (w_redir) begin
                        r_state <= (w_out_next != '0) ? S_FLUSH : S_FETCH;
                    end else if (r_state == S_FLUSH && r_discard == '0) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_issue) begin
            r_tag[r_tag_wr] <= r_pc;
        end
        if (w_push) begin
            r_buf_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
            r_buf_instr[r_wr_ptr] <= imem_rdata_i;
        end
    end

    a_rvalid_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (r_outstanding != '0)
    );

endmodule

// File: tb/tb_beta_fetch_pc.sv
// tb_beta_fetch_pc: randomized fetch-stage bench with a memory responder
// and an instruction-stream reference model.

module tb_beta_fetch_pc;

    localparam int          DEPTH = 2;
    localparam logic [31:0] BOOT  = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        redirect_misalig_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_o;
    logic        if_ready_i;
    logic        if_misalig_exc_o;

    always #5 clk_i = ~clk_i;

    beta_fetch_pc #(
        .DATAWIDTH (32),
        .BOOT_ADDR (BOOT),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .imem_req_o        (imem_req_o),
        .imem_addr_o       (imem_addr_o),
        .imem_gnt_i        (imem_gnt_i),
        .imem_rvalid_i     (imem_rvalid_i),
        .imem_rdata_i      (imem_rdata_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .redirect_misalig_i(redirect_misalig_i),
        .if_valid_o        (if_valid_o),
        .if_instr_o        (if_instr_o),
        .if_pc_o           (if_pc_o),
        .if_ready_i        (if_ready_i),
        .if_misalig_exc_o  (if_misalig_exc_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // responder and model state
    int          cyc = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    int          b_out, b_drop, b_occ;
    logic [31:0] exp_req, exp_deliv;
    bit          prev_mis, prev_wait, in_boot;
    logic [31:0] prev_addr;
    bit          last_req, last_exc;
    int          n_deliv = 0;
    logic [31:0] glog[$];
    logic [31:0] dlog[$];

    // knobs
    int          k_gnt = 100, k_rdy = 100, k_lat_min = 1, k_lat_max = 1;
    bit          k_redir = 0, k_mis = 0;
    logic [31:0] k_tgt = '0;

    task automatic step();
        bit g, rv, rd, red, mis, iss, pop;
        logic [31:0] a;
        @(negedge clk_i);
        cyc++;
        last_req = imem_req_o;
        last_exc = if_misalig_exc_o;
        chk("exc", 32'(if_misalig_exc_o), 32'(prev_mis));
        chk("valid", 32'(if_valid_o), 32'(b_occ > 0));
        if (in_boot) chk("boot_noreq", 32'(imem_req_o), 32'd0);
        in_boot = 0;
        if (imem_req_o)
            chk("req_budget", 32'(b_out + b_occ < DEPTH), 32'd1);
        if (prev_wait) begin
            chk("req_hold", 32'(imem_req_o), 32'd1);
            chk("addr_hold", imem_addr_o, prev_addr);
        end

        red = k_redir;
        mis = k_mis;
        k_redir = 0;
        g  = ($urandom_range(99) < k_gnt);
        rd = red ? 1'b0 : ($urandom_range(99) < k_rdy);
        rv = (pend_due.size() > 0) && (pend_due[0] <= cyc);
        imem_gnt_i         = g;
        imem_rvalid_i      = rv;
        imem_rdata_i       = rv ? mem_word(pend_addr[0]) : $urandom;
        if_ready_i         = rd;
        redirect_i         = red;
        redirect_misalig_i = mis;
        redirect_pc_i      = red ? k_tgt : $urandom;

        iss = imem_req_o & g;
        pop = rd & if_valid_o;
        if (iss) begin
            chk("req_addr", imem_addr_o, exp_req);
            glog.push_back(imem_addr_o);
            pend_addr.push_back(imem_addr_o);
            pend_due.push_back(cyc + $urandom_range(k_lat_max, k_lat_min));
            exp_req += 32'd4;
        end
        if (rv) begin
            a = pend_addr.pop_front();
            void'(pend_due.pop_front());
        end
        if (pop) begin
            chk("pc", if_pc_o, exp_deliv);
            chk("instr", if_instr_o, mem_word(exp_deliv));
            dlog.push_back(if_pc_o);
            exp_deliv += 32'd4;
            n_deliv++;
        end
        b_out = b_out + int'(iss) - int'(rv);
        if (red && !mis) begin
            b_occ     = 0;
            b_drop    = b_out;
            exp_req   = k_tgt;
            exp_deliv = k_tgt;
        end else begin
            if (rv) begin
                if (b_drop > 0) b_drop--;
                else b_occ++;
            end
            if (pop) b_occ--;
        end
        prev_mis  = red & mis;
        prev_wait = imem_req_o & ~g & ~(red & ~mis);
        prev_addr = imem_addr_o;
    endtask

    task automatic do_reset();
        #2;
        rst_i              = 1'b1;
        imem_gnt_i         = 1'b0;
        imem_rvalid_i      = 1'b0;
        imem_rdata_i       = '0;
        redirect_i         = 1'b0;
        redirect_pc_i      = '0;
        redirect_misalig_i = 1'b0;
        if_ready_i         = 1'b0;
        #1;
        chk("rst_valid", 32'(if_valid_o), 32'd0);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_addr", imem_addr_o, BOOT);
        chk("rst_exc", 32'(if_misalig_exc_o), 32'd0);
        pend_addr.delete();
        pend_due.delete();
        b_out = 0; b_drop = 0; b_occ = 0;
        exp_req = BOOT; exp_deliv = BOOT;
        prev_mis = 0; prev_wait = 0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        in_boot = 1;
    endtask

    initial begin
        int g0, d0, n;
        rst_i = 1'b1;
        do_reset();

        // 1: straight-line fetch
        k_gnt = 100; k_rdy = 100; k_lat_min = 1; k_lat_max = 1;
        g0 = glog.size(); d0 = dlog.size();
        repeat (8) step();
        chk("t1_ngrant", 32'(glog.size() - g0 >= 3), 32'd1);
        chk("t1_ndeliv", 32'(dlog.size() - d0 >= 3), 32'd1);
        if (glog.size() - g0 >= 3 && dlog.size() - d0 >= 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("t1_req", glog[g0+i], BOOT + 32'(4 * i));
                chk("t1_pc", dlog[d0+i], BOOT + 32'(4 * i));
            end
        end

        // 2: decode stalled
        do_reset();
        k_rdy = 0;
        g0 = glog.size();
        repeat (10) step();
        chk("t2_ngrant", 32'(glog.size() - g0), 32'd2);
        k_rdy = 100;
        step();
        chk("t2_popcycle_req", 32'(last_req), 32'd0);
        k_rdy = 0;
        step();
        chk("t2_resume", 32'(last_req), 32'd1);

        // 3: redirect with two in flight
        do_reset();
        k_rdy = 100; k_lat_min = 3; k_lat_max = 3;
        n = 0;
        while (b_out < 2 && n < 20) begin
            step();
            n++;
        end
        chk("t3_setup", 32'(b_out), 32'd2);
        g0 = glog.size(); d0 = dlog.size();
        k_redir = 1; k_mis = 0; k_tgt = 32'h100;
        repeat (12) step();
        chk("t3_ngrant", 32'(glog.size() > g0), 32'd1);
        chk("t3_ndeliv", 32'(dlog.size() > d0), 32'd1);
        if (glog.size() > g0) chk("t3_req", glog[g0], 32'h100);
        if (dlog.size() > d0) chk("t3_pc", dlog[d0], 32'h100);

        // 4: misaligned redirect rejected
        k_lat_min = 1; k_lat_max = 2;
        d0 = dlog.size();
        k_redir = 1; k_mis = 1; k_tgt = 32'h102;
        step();
        chk("t4_noexc_now", 32'(last_exc), 32'd0);
        step();
        chk("t4_exc_pulse", 32'(last_exc), 32'd1);
        step();
        chk("t4_exc_end", 32'(last_exc), 32'd0);
        repeat (8) step();
        chk("t4_stream", 32'(dlog.size() > d0), 32'd1);

        // 5: redirect during boot to the top word, PC wraps
        do_reset();
        k_lat_min = 1; k_lat_max = 1;
        g0 = glog.size();
        k_redir = 1; k_mis = 0; k_tgt = 32'hFFFF_FFFC;
        repeat (6) step();
        chk("t5_ngrant", 32'(glog.size() - g0 >= 2), 32'd1);
        if (glog.size() - g0 >= 2) begin
            chk("t5_top", glog[g0], 32'hFFFF_FFFC);
            chk("t5_wrap", glog[g0+1], 32'h0000_0000);
        end

        // 6: reset mid-operation
        k_rdy = 0; k_lat_min = 2; k_lat_max = 2;
        repeat (6) step();
        chk("t6_full", 32'(if_valid_o), 32'd1);
        do_reset();
        k_rdy = 100;
        g0 = glog.size();
        repeat (3) step();
        chk("t6_ngrant", 32'(glog.size() > g0), 32'd1);
        if (glog.size() > g0) chk("t6_boot_addr", glog[g0], BOOT);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                k_gnt     = $urandom_range(100, 30);
                k_rdy     = $urandom_range(100, 20);
                k_lat_min = 1;
                k_lat_max = $urandom_range(4, 1);
            end
            if (i == 1500) do_reset();
            if ($urandom_range(99) < 3) begin
                k_redir = 1;
                k_mis   = $urandom_range(1);
                if ($urandom_range(3) == 0) k_tgt = 32'hFFFF_FFF8;
                else k_tgt = $urandom & 32'hFFFF_FFFC;
                if (k_mis) k_tgt = k_tgt | 32'(($urandom_range(2)) + 1);
            end
            step();
        end
        chk("progress", 32'(n_deliv > 500), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
